// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and the occupancy-flag helper for sync_fifo.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package sync_fifo_pkg;

  // The four occupancy flags, kept together so they are registered as one bundle.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Flag values a FIFO holding 'count' words must present.
  function automatic fifo_flags_t calc_flags(input int unsigned count,
                                             input int unsigned depth,
                                             input int unsigned afull_th,
                                             input int unsigned aempty_th);
    fifo_flags_t f;
    f.full         = (count == depth);
    f.empty        = (count == 0);
    f.almost_full  = (count >= afull_th);
    f.almost_empty = (count <= aempty_th);
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: single-clock dual-port storage, one write and one registered read port.
// Latency: read data appears one clock after R_EN is sampled.
// Backpressure: none; the caller gates W_EN/R_EN. RDATA holds while R_EN is low.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_EN,
  input  logic [ADDR_WIDTH-1:0] W_ADDR,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  R_EN,
  input  logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic [DATA_WIDTH-1:0] RDATA
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array write; contents deliberately left unreset so it maps onto plain RAM.
  always_ff @(posedge CLK) begin
    if (W_EN) begin
      mem[W_ADDR] <= WDATA;
    end
  end

  // Read register; only this output register is reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RDATA <= '0;
    end else if (R_EN) begin
      RDATA <= mem[R_ADDR];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count, full/empty and almost flags; SYNC_FIFO_ERR_EN adds sticky OVERFLOW/UNDERFLOW.
// Latency: accepted read returns RDATA with RVALID after the accepting edge; flags/COUNT update at the accepting edge.
// Backpressure: writes dropped while FULL, reads dropped while EMPTY (no pass-through, no bypass).
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_EN,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  R_EN,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  RVALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                  ERR_CLR,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic                wr_acc, rd_acc;
  fifo_flags_t         flags, flags_nxt;

  // Accept decisions use only registered flags; next count falls out of the
  // extra pointer bit, so the pointer difference is 0..DEPTH with no wrap case.
  always_comb begin
    wr_acc     = W_EN && !flags.full;
    rd_acc     = R_EN && !flags.empty;
    wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_acc};
    rd_ptr_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_acc};
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    flags_nxt  = calc_flags(32'(count_nxt), DEPTH, AFULL_THRESH, AEMPTY_THRESH);
  end

  // Pointer, count, flag and read-valid registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
      flags  <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      RVALID <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      COUNT  <= count_nxt;
      flags  <= flags_nxt;
      RVALID <= rd_acc;
    end
  end

  assign FULL         = flags.full;
  assign EMPTY        = flags.empty;
  assign ALMOST_FULL  = flags.almost_full;
  assign ALMOST_EMPTY = flags.almost_empty;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .CLK    (CLK),
    .RST    (RST),
    .W_EN   (wr_acc),
    .W_ADDR (wr_ptr[ADDR_WIDTH-1:0]),
    .WDATA  (WDATA),
    .R_EN   (rd_acc),
    .R_ADDR (rd_ptr[ADDR_WIDTH-1:0]),
    .RDATA  (RDATA)
  );

`ifdef SYNC_FIFO_ERR_EN
  // Sticky error flags; a new error in the same cycle beats ERR_CLR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (W_EN && flags.full) begin
        OVERFLOW <= 1'b1;
      end else if (ERR_CLR) begin
        OVERFLOW <= 1'b0;
      end
      if (R_EN && flags.empty) begin
        UNDERFLOW <= 1'b1;
      end else if (ERR_CLR) begin
        UNDERFLOW <= 1'b0;
      end
    end
  end
`else
  // Without error tracking, dropped requests leave no trace.
`endif

endmodule
